// File: rtl/wfg_record_pat_pkg.sv
`default_nettype none
// ============================================================================
// wfg_record_pat_pkg : register map, bit positions and shared types
// Revision 1.0
// ============================================================================
package wfg_record_pat_pkg;

   localparam logic [1:0] c_reg_ctrl      = 2'd0;
   localparam logic [1:0] c_reg_mask      = 2'd1;
   localparam logic [1:0] c_reg_frame_len = 2'd2;
   localparam logic [1:0] c_reg_status    = 2'd3;

   localparam int c_ctrl_en_bit     = 0;
   localparam int c_status_ovf_bit  = 0;
   localparam int c_status_fill_lsb = 8;
   localparam int c_fill_w          = 8;
   localparam int c_frame_len_w     = 16;

   typedef struct packed {
      logic                     en;
      logic [c_frame_len_w-1:0] frame_len;
      logic                     ovf_clr;
   } wfg_regs_t;

endpackage
`default_nettype wire

// File: rtl/wfg_record_pat_wishbone_reg.sv
`default_nettype none
// ============================================================================
// wfg_record_pat_wishbone_reg : Wishbone slave register file (CTRL/MASK/FRAME_LEN/STATUS)
// Revision 1.0
// ============================================================================
module wfg_record_pat_wishbone_reg
   import wfg_record_pat_pkg::*;
#(
   parameter int BUSW     = 32,
   parameter int CHANNELS = 32
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [BUSW-1:0]     wbs_dat_i,
   input  logic [BUSW-1:0]     wbs_adr_i,
   output logic                wbs_ack_o,
   output logic [BUSW-1:0]     wbs_dat_o,
   input  logic                ovf_i,
   input  logic [c_fill_w-1:0] fill_i,
   output wfg_regs_t           regs_o,
   output logic [CHANNELS-1:0] mask_o
);

   logic                     ack_q;
   logic [BUSW-1:0]          dat_q;
   logic                     en_q;
   logic [c_frame_len_w-1:0] flen_q;
   logic [CHANNELS-1:0]      mask_q;

   logic            w_req;
   logic            w_wr;
   logic [1:0]      w_idx;
   logic [BUSW-1:0] w_rdata;
   logic            w_unused;

   // A request is only taken while ack is low, so ack toggles under a held strobe.
   assign w_req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
   assign w_wr     = w_req & wbs_we_i;
   assign w_idx    = wbs_adr_i[3:2];
   assign w_unused = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

   always_comb begin
      w_rdata = '0;
      case (w_idx)
         c_reg_ctrl:      w_rdata[c_ctrl_en_bit] = en_q;
         c_reg_mask:      w_rdata[CHANNELS-1:0] = mask_q;
         c_reg_frame_len: w_rdata[c_frame_len_w-1:0] = flen_q;
         c_reg_status: begin
            w_rdata[c_status_ovf_bit]               = ovf_i;
            w_rdata[c_status_fill_lsb +: c_fill_w] = fill_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q  <= 1'b0;
         dat_q  <= '0;
         en_q   <= 1'b0;
         flen_q <= '0;
         mask_q <= '0;
      end else begin
         ack_q <= w_req;
         dat_q <= (w_req && !wbs_we_i) ? w_rdata : '0;
         if (w_wr) begin
            case (w_idx)
               c_reg_ctrl:      en_q   <= wbs_dat_i[c_ctrl_en_bit];
               c_reg_mask:      mask_q <= wbs_dat_i[CHANNELS-1:0];
               c_reg_frame_len: flen_q <= wbs_dat_i[c_frame_len_w-1:0];
               default: ;
            endcase
         end
      end
   end

   assign wbs_ack_o        = ack_q;
   assign wbs_dat_o        = dat_q;
   assign mask_o           = mask_q;
   assign regs_o.en        = en_q;
   assign regs_o.frame_len = flen_q;
   assign regs_o.ovf_clr   = w_wr & (w_idx == c_reg_status) & wbs_dat_i[c_status_ovf_bit];

endmodule
`default_nettype wire

// File: rtl/wfg_record_pat.sv
`default_nettype none
// ============================================================================
// wfg_record_pat : pin pattern recorder, FIFO + frame counter to AXI-Stream; WFG_RECORD_PAT_SYNC_EN adds a 2-flop pin synchronizer
// Revision 1.0
// ============================================================================
module wfg_record_pat
   import wfg_record_pat_pkg::*;
#(
   parameter int BUSW            = 32,
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int CHANNELS        = 32,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic                       wbs_stb_i,
   input  logic                       wbs_cyc_i,
   input  logic                       wbs_we_i,
   input  logic [3:0]                 wbs_sel_i,
   input  logic [BUSW-1:0]            wbs_dat_i,
   input  logic [BUSW-1:0]            wbs_adr_i,
   output logic                       wbs_ack_o,
   output logic [BUSW-1:0]            wbs_dat_o,
   input  logic                       wfg_core_sync_i,
   input  logic [7:0]                 wfg_core_subcycle_cnt_i,
   input  logic [CHANNELS-1:0]        pat_din_i,
   input  logic                       wfg_axis_tready_i,
   output logic                       wfg_axis_tvalid_o,
   output logic                       wfg_axis_tlast_o,
   output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o
);

   localparam int                c_ptr_w   = $clog2(FIFO_DEPTH);
   localparam logic [c_ptr_w:0]  c_depth   = (c_ptr_w+1)'(FIFO_DEPTH);
   localparam logic [c_ptr_w:0]  c_ptr_one = 1;
   localparam logic [c_frame_len_w-1:0] c_idx_one = 1;

   typedef struct packed {
      logic                last;
      logic [CHANNELS-1:0] data;
   } ent_t;

   ent_t                     mem_q [FIFO_DEPTH];
   logic [c_ptr_w:0]         wr_ptr_q, wr_ptr_d;
   logic [c_ptr_w:0]         rd_ptr_q, rd_ptr_d;
   logic [c_frame_len_w-1:0] idx_q, idx_d;
   logic                     ovf_q, ovf_d;
   logic                     en_prev_q;

   wfg_regs_t                w_regs;
   logic [CHANNELS-1:0]      w_mask;
   logic [CHANNELS-1:0]      w_pins;
   logic [CHANNELS-1:0]      w_sample;
   logic [c_ptr_w:0]         w_count;
   logic [c_fill_w-1:0]      w_fill;
   logic                     w_empty, w_full, w_pop, w_push, w_drop, w_last;
   logic [c_frame_len_w-1:0] w_idx_base;
   ent_t                     w_head;
   logic                     w_unused;

   wfg_record_pat_wishbone_reg #(
      .BUSW     (BUSW),
      .CHANNELS (CHANNELS)
   ) u_regs (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .ovf_i     (ovf_q),
      .fill_i    (w_fill),
      .regs_o    (w_regs),
      .mask_o    (w_mask)
   );

`ifdef WFG_RECORD_PAT_SYNC_EN
   logic [CHANNELS-1:0] pin_s1_q, pin_s2_q;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         pin_s1_q <= '0;
         pin_s2_q <= '0;
      end else begin
         pin_s1_q <= pat_din_i;
         pin_s2_q <= pin_s1_q;
      end
   end

   assign w_pins = pin_s2_q;
`else
   assign w_pins = pat_din_i;
`endif

   assign w_unused = ^wfg_core_subcycle_cnt_i;
   assign w_sample = w_pins & w_mask;
   assign w_count  = wr_ptr_q - rd_ptr_q;
   assign w_fill   = c_fill_w'(w_count);
   assign w_empty  = (w_count == '0);
   assign w_full   = (w_count == c_depth);
   assign w_head   = mem_q[rd_ptr_q[c_ptr_w-1:0]];

   always_comb begin
      w_pop  = ~w_empty & wfg_axis_tready_i;
      // A full FIFO still accepts a sample when the head leaves in the same cycle.
      w_push = w_regs.en & wfg_core_sync_i & (~w_full | w_pop);
      w_drop = w_regs.en & wfg_core_sync_i & w_full & ~w_pop;

      // The first enabled cycle after EN rises restarts the frame at index 0.
      w_idx_base = (w_regs.en && !en_prev_q) ? '0 : idx_q;
      w_last     = (w_regs.frame_len != '0) && (w_idx_base == (w_regs.frame_len - c_idx_one));

      idx_d = w_idx_base;
      if (w_push) begin
         idx_d = w_last ? '0 : (w_idx_base + c_idx_one);
      end

      wr_ptr_d = w_push ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
      rd_ptr_d = w_pop  ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;

      ovf_d = ovf_q;
      if (w_regs.ovf_clr) ovf_d = 1'b0;
      if (w_drop)         ovf_d = 1'b1;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         idx_q     <= '0;
         ovf_q     <= 1'b0;
         en_prev_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         idx_q     <= idx_d;
         ovf_q     <= ovf_d;
         en_prev_q <= w_regs.en;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (w_push) begin
         mem_q[wr_ptr_q[c_ptr_w-1:0]] <= '{last: w_last, data: w_sample};
      end
   end

   // Storage is not reset, so outputs are gated by the empty flag.
   always_comb begin
      wfg_axis_tdata_o = '0;
      if (!w_empty) begin
         wfg_axis_tdata_o[CHANNELS-1:0] = w_head.data;
      end
   end

   assign wfg_axis_tvalid_o = ~w_empty;
   assign wfg_axis_tlast_o  = ~w_empty & w_head.last;

endmodule
`default_nettype wire

// File: tb/tb_wfg_record_pat.sv
`default_nettype none
// ============================================================================
// tb_wfg_record_pat : directed and random stimulus against a queue-based reference model
// Revision 1.0
// ============================================================================
module tb_wfg_record_pat;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] wdat = '0;
   logic [31:0] adr = '0;
   logic        ack;
   logic [31:0] rdat;
   logic        sync = 1'b0;
   logic [7:0]  subcyc = '0;
   logic [31:0] pins = '0;
   logic        tready = 1'b0;
   logic        tvalid, tlast;
   logic [31:0] tdata;

   always #5 clk = ~clk;

   wfg_record_pat dut (
      .wb_clk_i                (clk),
      .wb_rst_i                (rst),
      .wbs_stb_i               (stb),
      .wbs_cyc_i               (stb),
      .wbs_we_i                (we),
      .wbs_sel_i               (sel),
      .wbs_dat_i               (wdat),
      .wbs_adr_i               (adr),
      .wbs_ack_o               (ack),
      .wbs_dat_o               (rdat),
      .wfg_core_sync_i         (sync),
      .wfg_core_subcycle_cnt_i (subcyc),
      .pat_din_i               (pins),
      .wfg_axis_tready_i       (tready),
      .wfg_axis_tvalid_o       (tvalid),
      .wfg_axis_tlast_o        (tlast),
      .wfg_axis_tdata_o        (tdata)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: queue of {last, data} plus register shadow state.
   logic [32:0] m_q[$];
   logic        m_en, m_ovf, m_ack;
   logic [31:0] m_mask, m_dat;
   logic [15:0] m_flen;
   int unsigned m_idx;
   logic [31:0] m_hist[2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_en = 0; m_ovf = 0; m_ack = 0;
      m_mask = '0; m_dat = '0; m_flen = '0; m_idx = 0;
      m_hist[0] = '0; m_hist[1] = '0;
   endtask

   task automatic model_step();
      logic        pop, req, full, last, drop;
      logic [31:0] samp, nd;
      pop = (m_q.size() != 0) && tready;
      req = stb && !m_ack;
      nd  = '0;
      if (req && !we) begin
         case (adr[3:2])
            2'd0:    nd = {31'd0, m_en};
            2'd1:    nd = m_mask;
            2'd2:    nd = {16'd0, m_flen};
            default: nd = {16'd0, 8'(m_q.size()), 7'd0, m_ovf};
         endcase
      end
`ifdef WFG_RECORD_PAT_SYNC_EN
      samp = m_hist[1] & m_mask;
`else
      samp = pins & m_mask;
`endif
      drop = 0;
      full = (m_q.size() >= DEPTH);
      if (pop) void'(m_q.pop_front());
      if (sync && m_en) begin
         if (!full || pop) begin
            last = (m_flen != 0) && (m_idx == m_flen - 1);
            m_q.push_back({last, samp});
            m_idx = last ? 0 : (m_idx + 1) % 65536;
         end else begin
            drop = 1;
         end
      end
      if (req && we && adr[3:2] == 2'd3 && wdat[0]) m_ovf = 0;
      if (drop) m_ovf = 1;
      if (req && we) begin
         case (adr[3:2])
            2'd0: begin
               if (!m_en && wdat[0]) m_idx = 0;
               m_en = wdat[0];
            end
            2'd1: m_mask = wdat;
            2'd2: m_flen = wdat[15:0];
            default: ;
         endcase
      end
      m_ack = req;
      m_dat = nd;
      m_hist[1] = m_hist[0];
      m_hist[0] = pins;
   endtask

   task automatic check_outputs();
      check("tvalid", tvalid, m_q.size() != 0);
      if (m_q.size() != 0) begin
         check("tdata", tdata, m_q[0][31:0]);
         check("tlast", tlast, m_q[0][32]);
      end
      check("ack", ack, m_ack);
      if (m_ack) check("rdat", rdat, m_dat);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
      stb = 1; we = 1; adr = a; wdat = d;
      step();
      stb = 0; we = 0;
      step();
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] v);
      stb = 1; we = 0; adr = a;
      step();
      v = rdat;
      stb = 0;
      step();
   endtask

   initial begin
      logic [31:0] v;
      int          hold;
      model_reset();
      #2;
      check("rst_ack", ack, 0);
      check("rst_rdat", rdat, 0);
      check("rst_tvalid", tvalid, 0);
      check("rst_tlast", tlast, 0);
      check("rst_tdata", tdata, 0);
      @(negedge clk);
      rst = 0;

      // Single sample, full mask
      tready = 1;
      wb_write(32'h4, 32'hFFFF_FFFF);
      wb_write(32'h0, 32'h1);
      pins = 32'hA5A5_A5A5; sync = 1;
      step();
      sync = 0;
      check("single_tvalid", tvalid, 1);
      check("single_tdata", tdata, 32'hA5A5_A5A5);
      step();
      check("single_once", tvalid, 0);

      // Partial mask
      wb_write(32'h4, 32'h0000_FFFF);
      pins = 32'h1234_5678; sync = 1;
      step();
      sync = 0;
      check("mask_tdata", tdata, 32'h0000_5678);
      step();

      // Frame length 3, seven samples
      wb_write(32'h4, 32'hFFFF_FFFF);
      wb_write(32'h8, 32'd3);
      wb_write(32'h0, 32'h0);
      wb_write(32'h0, 32'h1);
      for (int i = 0; i < 7; i++) begin
         pins = 32'(i); sync = 1;
         step();
         check("frame_tlast", tlast, (i == 2 || i == 5));
      end
      sync = 0;
      step();

      // Overflow with stalled sink, then W1C
      wb_write(32'h8, 32'd0);
      tready = 0;
      for (int i = 0; i < 5; i++) begin
         pins = $urandom; sync = 1;
         step();
      end
      sync = 0;
      wb_read(32'hC, v);
      check("ovf_status", v, 32'h0000_0401);
      wb_write(32'hC, 32'h1);
      wb_read(32'hC, v);
      check("ovf_cleared", v, 32'h0000_0400);

      // Full FIFO: pop and push in the same cycle
      tready = 1; pins = 32'hCAFE_0001; sync = 1;
      step();
      sync = 0; tready = 0;
      wb_read(32'hC, v);
      check("full_pushpop", v, 32'h0000_0400);
      tready = 1;
      repeat (6) step();

      // Reset with samples queued
      tready = 0;
      for (int i = 0; i < 2; i++) begin
         pins = $urandom; sync = 1;
         step();
      end
      sync = 0;
      rst = 1;
      #1;
      check("midrst_tvalid", tvalid, 0);
      model_reset();
      @(negedge clk);
      rst = 0;
      tready = 1;
      for (int i = 0; i < 3; i++) begin
         pins = $urandom; sync = 1;
         step();
         check("postrst_idle", tvalid, 0);
      end
      sync = 0;
      wb_write(32'h4, 32'hFFFF_FFFF);
      wb_write(32'h0, 32'h1);
      pins = 32'h0BAD_F00D; sync = 1;
      step();
      sync = 0;
      check("postrst_resume", tdata, 32'h0BAD_F00D);

      // Random traffic
      wb_write(32'h4, $urandom);
      wb_write(32'h8, 32'($urandom_range(0, 5)));
      wb_write(32'h0, 32'h1);
      hold = 0;
      for (int i = 0; i < 800; i++) begin
         sync   = ($urandom_range(0, 1) == 1);
         pins   = $urandom;
         tready = ($urandom_range(0, 9) < 6);
         if (hold > 0) begin
            hold--;
         end else begin
            stb = 0; we = 0;
            if ($urandom_range(0, 11) == 0) begin
               stb  = 1;
               hold = $urandom_range(0, 2);
               we   = ($urandom_range(0, 2) != 0);
               adr  = 32'($urandom_range(0, 3)) << 2;
               case (adr[3:2])
                  2'd0:    wdat = ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0;
                  2'd2:    wdat = 32'($urandom_range(0, 5));
                  default: wdat = $urandom;
               endcase
            end
         end
         step();
      end
      stb = 0; we = 0; sync = 0; tready = 1;
      repeat (8) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wfg_record_pat.md
WFG_RECORD_PAT -- requirements
Module: wfg_record_pat

Interface
REQ-001 The block SHALL have parameter BUSW, default 32, Wishbone address/data width.
REQ-002 The block SHALL have parameter AXIS_DATA_WIDTH, default 32, AXI-Stream tdata width.
REQ-003 The block SHALL have parameter CHANNELS, default 32, sampled pin count (<= AXIS_DATA_WIDTH, zero-extended in tdata).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, sample buffer entries (power of two, >= 2).
REQ-005 The block SHALL use one clock and an asynchronous active-high reset, on ports wb_clk_i and wb_rst_i.
REQ-006 Ports SHALL be: wb_clk_i in 1, clock; wb_rst_i in 1, async active-high reset.
REQ-007 Ports SHALL be: wbs_stb_i in 1, wbs_cyc_i in 1, wbs_we_i in 1, wbs_sel_i in 4, wbs_dat_i in BUSW, wbs_adr_i in BUSW; wbs_ack_o out 1, wbs_dat_o out BUSW (Wishbone slave).
REQ-008 Ports SHALL be: wfg_core_sync_i in 1, sample strobe; wfg_core_subcycle_cnt_i in 8, unused, kept for bus uniformity.
REQ-009 Ports SHALL be: pat_din_i in CHANNELS, sampled pins.
REQ-010 Ports SHALL be: wfg_axis_tready_i in 1; wfg_axis_tvalid_o out 1; wfg_axis_tlast_o out 1; wfg_axis_tdata_o out AXIS_DATA_WIDTH (AXI-Stream master).

Function
REQ-011 Registers SHALL be: 0x0 CTRL (bit0 EN), 0x4 MASK (CHANNELS bits), 0x8 FRAME_LEN (16 bits), 0xC STATUS (bit0 OVF sticky, bits[15:8] fill level), all word-addressed via wbs_adr_i[3:2], wbs_sel_i ignored.
REQ-012 wbs_ack_o SHALL pulse for one cycle, one cycle after stb&cyc, and SHALL be low the following cycle even if stb&cyc stay high.
REQ-013 Writing 1 to STATUS bit0 SHALL clear OVF; other STATUS bits are read-only; unmapped reads return 0.
REQ-014 When EN=1 and wfg_core_sync_i=1, the block SHALL push (pat_din_i & MASK) into the FIFO that cycle.
REQ-015 A pushed sample SHALL appear with wfg_axis_tvalid_o=1 at the next rising edge if the FIFO was empty (1-cycle latency).
REQ-016 tvalid/tdata/tlast SHALL remain stable while tvalid=1 and tready=0; pop occurs on tvalid&tready.
REQ-017 A push with FIFO full and no same-cycle pop SHALL drop the sample and set OVF; push and pop in the same cycle on a full FIFO SHALL succeed.
REQ-018 A sample-index counter SHALL count accepted pushes; the sample with index FRAME_LEN-1 SHALL carry tlast=1 and the counter then wraps to 0.
REQ-019 FRAME_LEN=0 SHALL never assert tlast; dropped samples SHALL NOT advance the counter.
REQ-020 EN 1->0 SHALL stop sampling immediately; queued samples SHALL still drain on the stream.
REQ-021 EN 0->1 SHALL reset the sample-index counter to 0 without flushing the FIFO.
REQ-022 A bus write to CTRL and a sync in the same cycle SHALL use the pre-write EN value.

Reset
REQ-023 On wb_rst_i=1 the block SHALL asynchronously clear CTRL, MASK, FRAME_LEN, OVF, FIFO pointers and the counter.
REQ-024 Reset values SHALL be: wbs_ack_o=0, wbs_dat_o=0, wfg_axis_tvalid_o=0, wfg_axis_tlast_o=0, wfg_axis_tdata_o=0.
REQ-025 Reset asserted mid-frame SHALL discard all queued samples; no tvalid SHALL follow release until a new sync with EN=1.

Configuration
REQ-026 Macro WFG_RECORD_PAT_SYNC_EN defined SHALL insert a two-flop synchronizer on pat_din_i, sampling pins as of 2 cycles before the sync strobe.
REQ-027 Macro WFG_RECORD_PAT_SYNC_EN undefined SHALL sample pat_din_i directly in the sync cycle; all other behaviour is identical.

Structure
REQ-028 Package wfg_record_pat_pkg SHALL hold the register offsets, CTRL/STATUS bit positions and the register-file struct typedef.
REQ-029 Sub-module wfg_record_pat_wishbone_reg SHALL implement the Wishbone register file; the core (FIFO, counter, AXIS) SHALL live in wfg_record_pat.

Verification
REQ-030 EN=1, MASK=0xFFFFFFFF, pins=0xA5A5A5A5, one sync, tready=1 -> tdata=0xA5A5A5A5, tvalid high exactly 1 cycle, 1 cycle after sync.
REQ-031 MASK=0x0000FFFF, pins=0x12345678 -> tdata=0x00005678.
REQ-032 FRAME_LEN=3, 7 syncs, tready=1 -> tlast on samples 3 and 6 only.
REQ-033 tready=0, 5 syncs, FIFO_DEPTH=4 -> 4 samples held stable, OVF=1, STATUS fill=4; W1C STATUS -> OVF=0.
REQ-034 Full FIFO, tready=1 and sync in the same cycle -> no drop, OVF stays 0.
REQ-035 Reset pulse with 2 samples queued -> tvalid=0 immediately, no output until next enabled sync.
